// File: rtl/serial_pair_serializer.sv
`default_nettype none
// ============================================================================
// Module      : serial_pair_serializer
// Description : Accepts a WIDTH-bit operand pair over valid/ready and shifts
//               it out one bit pair per clock on a/b.
//               Framing (bit_valid/first/last) lets a downstream serial
//               comparator restart at every word boundary.
//               Back-to-back words are produced with no bubble between them.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_pair_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [WIDTH-1:0] up_a,
  input  logic [WIDTH-1:0] up_b,
  output logic             a,
  output logic             b,
  output logic             bit_valid,
  output logic             first,
  output logic             last
);

  localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);
  localparam int            OUT_IDX  = MSB_FIRST ? (WIDTH - 1) : 0;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;

  // Output flops: every output is driven straight from a register so that
  // no up_* input can reach an output through logic.
  logic up_ready_q, up_ready_d;
  logic a_q, a_d;
  logic b_q, b_d;
  logic bit_valid_q, bit_valid_d;
  logic first_q, first_d;
  logic last_q, last_d;

  logic             accept;
  logic [WIDTH-1:0] sa_shift;
  logic [WIDTH-1:0] sb_shift;

  // Shift direction moves the next bit toward the output end.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign sa_shift = {sa_q[WIDTH-2:0], 1'b0};
      assign sb_shift = {sb_q[WIDTH-2:0], 1'b0};
    end else begin : g_lsb_first
      assign sa_shift = {1'b0, sa_q[WIDTH-1:1]};
      assign sb_shift = {1'b0, sb_q[WIDTH-1:1]};
    end
  endgenerate

  // up_ready is a registered signal, so the handshake never loops through
  // up_valid combinationally.
  assign accept = up_valid & up_ready_q;

  // Next-state logic: accept, shift, or return to idle at end of word;
  // output values are precomputed from the next state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sa_d    = sa_q;
    sb_d    = sb_q;

    if (accept) begin
      state_d = ST_SHIFT;
      cnt_d   = '0;
      sa_d    = up_a;
      sb_d    = up_b;
    end else if (state_q == ST_SHIFT) begin
      if (cnt_q == LAST_CNT) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + ONE_CNT;
        sa_d  = sa_shift;
        sb_d  = sb_shift;
      end
    end

    up_ready_d  = (state_d == ST_IDLE) || (cnt_d == LAST_CNT);
    bit_valid_d = (state_d == ST_SHIFT);
    first_d     = (state_d == ST_SHIFT) && (cnt_d == '0);
    last_d      = (state_d == ST_SHIFT) && (cnt_d == LAST_CNT);
    // Idle outputs are gated to 0 rather than showing stale register bits.
    a_d         = (state_d == ST_SHIFT) && sa_d[OUT_IDX];
    b_d         = (state_d == ST_SHIFT) && sb_d[OUT_IDX];
  end

  // State, datapath and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      sa_q        <= '0;
      sb_q        <= '0;
      up_ready_q  <= 1'b1;
      a_q         <= 1'b0;
      b_q         <= 1'b0;
      bit_valid_q <= 1'b0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sa_q        <= sa_d;
      sb_q        <= sb_d;
      up_ready_q  <= up_ready_d;
      a_q         <= a_d;
      b_q         <= b_d;
      bit_valid_q <= bit_valid_d;
      first_q     <= first_d;
      last_q      <= last_d;
    end
  end

  assign up_ready  = up_ready_q;
  assign a         = a_q;
  assign b         = b_q;
  assign bit_valid = bit_valid_q;
  assign first     = first_q;
  assign last      = last_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_pair_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_pair_serializer
// Description : Scoreboard bench driving an MSB-first and an LSB-first
//               instance from the same operand stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_pair_serializer;

  localparam int W = 8;

  typedef struct packed {
    logic a;
    logic b;
    logic f;
    logic l;
  } bit_t;

  logic         clk;
  logic         rst;
  logic         up_valid;
  logic [W-1:0] up_a;
  logic [W-1:0] up_b;

  logic m_up_ready, m_a, m_b, m_bit_valid, m_first, m_last;
  logic l_up_ready, l_a, l_b, l_bit_valid, l_first, l_last;

  bit_t q_m[$];
  bit_t q_l[$];

  int tests;
  int fails;

  serial_pair_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .up_valid(up_valid), .up_ready(m_up_ready),
    .up_a(up_a), .up_b(up_b), .a(m_a), .b(m_b), .bit_valid(m_bit_valid),
    .first(m_first), .last(m_last)
  );

  serial_pair_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .up_valid(up_valid), .up_ready(l_up_ready),
    .up_a(up_a), .up_b(up_b), .a(l_a), .b(l_b), .bit_valid(l_bit_valid),
    .first(l_first), .last(l_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a word becomes W bit-pairs in transmit order.
  task automatic push_word(input logic [W-1:0] va, input logic [W-1:0] vb);
    for (int i = 0; i < W; i++) begin
      bit_t e;
      int   im;
      im  = W - 1 - i;
      e.a = va[im];
      e.b = vb[im];
      e.f = (i == 0);
      e.l = (i == W - 1);
      q_m.push_back(e);
      e.a = va[i];
      e.b = vb[i];
      q_l.push_back(e);
    end
  endtask

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s t=%0t {ready,bv,a,b,first,last} got=%b exp=%b", name, $time, act, exp);
    end
  endtask

  // Monitor: each cycle compare outputs with the front of each lane's queue.
  always @(negedge clk) begin
    logic [5:0] e;
    if (q_m.size() > 0) e = {q_m.size() == 1, 1'b1, q_m[0]};
    else                e = 6'b100000;
    check("msb_lane", {m_up_ready, m_bit_valid, m_a, m_b, m_first, m_last}, e);
    if (q_m.size() > 0) void'(q_m.pop_front());

    if (q_l.size() > 0) e = {q_l.size() == 1, 1'b1, q_l[0]};
    else                e = 6'b100000;
    check("lsb_lane", {l_up_ready, l_bit_valid, l_a, l_b, l_first, l_last}, e);
    if (q_l.size() > 0) void'(q_l.pop_front());
  end

  // Present a pair, hold it until ready, then scramble inputs after accept.
  task automatic send(input logic [W-1:0] va, input logic [W-1:0] vb);
    int t;
    t = 0;
    @(negedge clk);
    #2;
    up_valid = 1'b1;
    up_a     = va;
    up_b     = vb;
    while (!m_up_ready && t < 64) begin
      @(negedge clk);
      #2;
      t++;
    end
    tests++;
    if (t >= 64) begin
      fails++;
      $display("FAIL send_timeout got=ready_low exp=ready_high");
      up_valid = 1'b0;
    end else begin
      push_word(va, vb);
      @(posedge clk);
      #2;
      up_valid = 1'b0;
      up_a     = W'($urandom);
      up_b     = W'($urandom);
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (q_m.size() != 0 && t < 64) begin
      @(negedge clk);
      t++;
    end
    tests++;
    if (t >= 64) begin
      fails++;
      $display("FAIL drain_timeout got=%0d exp=0", q_m.size());
    end
    @(negedge clk);
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    up_valid = 1'b0;
    up_a     = '0;
    up_b     = '0;
    rst      = 1'b1;
    #1 rst   = 1'b0;

    // Reset held with random inputs: outputs must stay idle.
    repeat (4) begin
      @(negedge clk);
      #2;
      up_valid = 1'($urandom);
      up_a     = W'($urandom);
      up_b     = W'($urandom);
    end
    #1;
    check("reset_msb", {m_up_ready, m_bit_valid, m_a, m_b, m_first, m_last}, 6'b100000);
    check("reset_lsb", {l_up_ready, l_bit_valid, l_a, l_b, l_first, l_last}, 6'b100000);
    up_valid = 1'b0;
    @(posedge clk);
    #3 rst = 1'b1;

    // Single word, then back-to-back, then LSB-oriented pattern.
    send(8'hA5, 8'h3C);
    wait_idle();
    send(8'hFF, 8'h00);
    send(8'h00, 8'hFF);
    wait_idle();
    send(8'h01, 8'h80);
    wait_idle();

    // Stability: inputs scrambled after accept, next request held mid-word.
    send(8'hC3, 8'h5A);
    send(8'h96, 8'h69);
    wait_idle();

    // Asynchronous reset during bit 3 aborts the word immediately.
    send(8'h3E, 8'hD1);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    q_m.delete();
    q_l.delete();
    check("midreset_msb", {m_up_ready, m_bit_valid, m_a, m_b, m_first, m_last}, 6'b100000);
    check("midreset_lsb", {l_up_ready, l_bit_valid, l_a, l_b, l_first, l_last}, 6'b100000);
    @(posedge clk);
    #3 rst = 1'b1;
    send(8'h0F, 8'hF0);
    wait_idle();

    // Random words with random gaps (0 gives back-to-back).
    for (int n = 0; n < 40; n++) begin
      send(W'($urandom), W'($urandom));
      repeat ($urandom_range(0, 3) * 4) @(negedge clk);
    end
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
